// File: rtl/audio_seq_pkg.sv
// Shared definitions for the audio sample sequencer: FSM encoding and default period.
package audio_seq_pkg;

    localparam int unsigned DIV_DEFAULT = 50000;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ADC_WAIT  = 2'd1,
        PROC_WAIT = 2'd2,
        DAC_WAIT  = 2'd3
    } seq_state_t;

endpackage

// File: rtl/tick_gen.sv
// Sample-period divider: free-running 0..DIV-1 counter that freezes while enable is low
// and emits a registered one-cycle tick on the cycle after each wrap.
module tick_gen
    import audio_seq_pkg::*;
#(
    parameter int unsigned DIV      = DIV_DEFAULT,
    parameter int unsigned CNT_BITS = 16
) (
    input  logic clock,
    input  logic reset,
    input  logic enable,
    output logic tick
);

    logic [CNT_BITS-1:0] count;

    always_ff @(posedge clock) begin
        if (reset) begin
            count <= '0;
            tick  <= 1'b0;
        end else begin
            tick <= 1'b0;
            if (enable) begin
                if (count == CNT_BITS'(DIV - 1)) begin
                    count <= '0;
                    tick  <= 1'b1;
                end else begin
                    count <= count + CNT_BITS'(1);
                end
            end
        end
    end

endmodule

// File: rtl/sample_sequencer.sv
// Per-sample ADC -> processing -> DAC handshake sequencer, paced by tick_gen.
// Every output is a flop; overrun flags ticks that arrive while a sequence is still running.
module sample_sequencer
    import audio_seq_pkg::*;
#(
    parameter int unsigned DIV      = DIV_DEFAULT,
    parameter int unsigned CNT_BITS = 16
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                enable,
    output logic                adc_req,
    input  logic                adc_ack,
    output logic                proc_start,
    input  logic                proc_done,
    output logic                dac_req,
    input  logic                dac_ack,
    output logic                tick,
    output logic                busy,
    output logic                overrun,
    input  logic                clear_overrun,
    output logic [CNT_BITS-1:0] sample_count
);

    seq_state_t state;
    seq_state_t state_next;
    logic       seq_done;

    tick_gen #(
        .DIV      (DIV),
        .CNT_BITS (CNT_BITS)
    ) u_tick_gen (
        .clock  (clock),
        .reset  (reset),
        .enable (enable),
        .tick   (tick)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Each handshake input is only looked at in its own wait state.
    always_comb begin
        state_next = state;
        seq_done   = 1'b0;
        case (state)
            IDLE:      if (tick)      state_next = ADC_WAIT;
            ADC_WAIT:  if (adc_ack)   state_next = PROC_WAIT;
            PROC_WAIT: if (proc_done) state_next = DAC_WAIT;
            DAC_WAIT: begin
                if (dac_ack) begin
                    state_next = IDLE;
                    seq_done   = 1'b1;
                end
            end
            default:   state_next = IDLE;
        endcase
    end

    // Outputs are registered from the next state so they line up with the state register.
    always_ff @(posedge clock) begin
        if (reset) begin
            adc_req      <= 1'b0;
            proc_start   <= 1'b0;
            dac_req      <= 1'b0;
            busy         <= 1'b0;
            overrun      <= 1'b0;
            sample_count <= '0;
        end else begin
            adc_req    <= (state_next == ADC_WAIT);
            proc_start <= (state == ADC_WAIT) && adc_ack;
            dac_req    <= (state_next == DAC_WAIT);
            busy       <= (state_next != IDLE);
            // A tick seen outside IDLE is dropped; setting beats a same-edge clear.
            if (tick && (state != IDLE)) begin
                overrun <= 1'b1;
            end else if (clear_overrun) begin
                overrun <= 1'b0;
            end
            if (seq_done) begin
                sample_count <= sample_count + CNT_BITS'(1);
            end
        end
    end

endmodule

// File: tb/tb_sample_sequencer.sv
// Directed bench for sample_sequencer with DIV=10, CNT_BITS=4: a per-cycle vector table
// for one full sequence plus hand-written overrun, wrap, reset and enable-freeze scenarios.
module tb_sample_sequencer;

    localparam int unsigned DIV      = 10;
    localparam int unsigned CNT_BITS = 4;

    logic                clock = 1'b0;
    logic                reset;
    logic                enable;
    logic                adc_req;
    logic                adc_ack;
    logic                proc_start;
    logic                proc_done;
    logic                dac_req;
    logic                dac_ack;
    logic                tick;
    logic                busy;
    logic                overrun;
    logic                clear_overrun;
    logic [CNT_BITS-1:0] sample_count;

    int tests = 0;
    int fails = 0;

    sample_sequencer #(
        .DIV      (DIV),
        .CNT_BITS (CNT_BITS)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .enable        (enable),
        .adc_req       (adc_req),
        .adc_ack       (adc_ack),
        .proc_start    (proc_start),
        .proc_done     (proc_done),
        .dac_req       (dac_req),
        .dac_ack       (dac_ack),
        .tick          (tick),
        .busy          (busy),
        .overrun       (overrun),
        .clear_overrun (clear_overrun),
        .sample_count  (sample_count)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic        en;
        logic        aa;
        logic        pd;
        logic        da;
        logic        clr;
        logic [10:0] exp;
    } vec_t;

    vec_t tbl[21];

    function automatic vec_t mk(input logic en, aa, pd, da, clr,
                                input logic tk, ar, ps, dr, bz, ov,
                                input logic [3:0] cnt);
        vec_t v;
        v.en  = en;
        v.aa  = aa;
        v.pd  = pd;
        v.da  = da;
        v.clr = clr;
        v.exp = {tk, ar, ps, dr, bz, ov, cnt};
        return v;
    endfunction

    function automatic logic [10:0] outs();
        return {tick, adc_req, proc_start, dac_req, busy, overrun, sample_count};
    endfunction

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic do_reset();
        reset         = 1'b1;
        enable        = 1'b0;
        adc_ack       = 1'b0;
        proc_done     = 1'b0;
        dac_ack       = 1'b0;
        clear_overrun = 1'b0;
        step();
        step();
        check("reset_state", int'(outs()), 0);
        reset  = 1'b0;
        enable = 1'b1;
    endtask

    task automatic wait_adc_req(input string name);
        bit seen = 1'b0;
        for (int k = 0; k < 20; k++) begin
            step();
            if (adc_req) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) begin
            tests++;
            fails++;
            $display("FAIL %s: adc_req not seen within 20 cycles, got 0, expected 1", name);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 9; i++) tbl[i] = mk(1,0,0,0,0, 0,0,0,0,0,0, 4'd0);
        tbl[9]  = mk(1,0,0,0,0, 1,0,0,0,0,0, 4'd0);
        tbl[10] = mk(1,0,0,0,0, 0,1,0,0,1,0, 4'd0);
        tbl[11] = mk(1,0,1,1,0, 0,1,0,0,1,0, 4'd0);
        tbl[12] = mk(1,1,0,0,0, 0,0,1,0,1,0, 4'd0);
        tbl[13] = mk(1,0,0,0,0, 0,0,0,0,1,0, 4'd0);
        tbl[14] = mk(1,0,0,0,0, 0,0,0,0,1,0, 4'd0);
        tbl[15] = mk(1,0,1,0,0, 0,0,0,1,1,0, 4'd0);
        tbl[16] = mk(1,0,0,1,0, 0,0,0,0,0,0, 4'd1);
        tbl[17] = mk(1,1,0,0,0, 0,0,0,0,0,0, 4'd1);
        tbl[18] = mk(1,0,0,0,0, 0,0,0,0,0,0, 4'd1);
        tbl[19] = mk(1,0,0,0,0, 1,0,0,0,0,0, 4'd1);
        tbl[20] = mk(1,0,0,0,0, 0,1,0,0,1,0, 4'd1);

        reset = 1'b1; enable = 1'b0; adc_ack = 1'b0; proc_done = 1'b0;
        dac_ack = 1'b0; clear_overrun = 1'b0;
        @(negedge clock);

        // Full sequence, cycle by cycle from reset release.
        do_reset();
        for (int i = 0; i < 21; i++) begin
            enable        = tbl[i].en;
            adc_ack       = tbl[i].aa;
            proc_done     = tbl[i].pd;
            dac_ack       = tbl[i].da;
            clear_overrun = tbl[i].clr;
            step();
            check($sformatf("vec_edge%0d", i + 1), int'(outs()), int'(tbl[i].exp));
        end

        // Overrun: processing stalls across two ticks, then clear behaviour.
        do_reset();
        repeat (11) step();
        check("ovr_adc_req", int'(adc_req), 1);
        adc_ack = 1'b1; step(); adc_ack = 1'b0;
        check("ovr_proc_start", int'(proc_start), 1);
        repeat (8) step();
        check("ovr_before_tick2", int'(overrun), 0);
        step();
        check("ovr_set_tick2", int'(overrun), 1);
        repeat (16) step();
        check("ovr_sticky", int'({overrun, busy, dac_req}), 3'b110);
        proc_done = 1'b1; step(); proc_done = 1'b0;
        check("ovr_dac_req", int'(dac_req), 1);
        dac_ack = 1'b1; step(); dac_ack = 1'b0;
        check("ovr_count", int'({busy, overrun, sample_count}), 6'b01_0001);
        clear_overrun = 1'b1; step(); clear_overrun = 1'b0;
        check("ovr_clear", int'({tick, overrun}), 2'b10);
        step();
        check("ovr_new_seq", int'({adc_req, overrun}), 2'b10);
        repeat (9) step();
        check("ovr_pre_tick", int'(overrun), 0);
        step();
        check("ovr_set_adc_wait", int'(overrun), 1);
        repeat (9) step();
        clear_overrun = 1'b1; step(); clear_overrun = 1'b0;
        check("ovr_clear_vs_set", int'(overrun), 1);
        clear_overrun = 1'b1; step(); clear_overrun = 1'b0;
        check("ovr_clear2", int'(overrun), 0);

        // 16 back-to-back sequences wrap the 4-bit counter with no overrun.
        do_reset();
        for (int i = 0; i < 16; i++) begin
            wait_adc_req($sformatf("wrap_req%0d", i));
            adc_ack = 1'b1; step(); adc_ack = 1'b0;
            proc_done = 1'b1; step(); proc_done = 1'b0;
            dac_ack = 1'b1; step(); dac_ack = 1'b0;
            check($sformatf("wrap_count%0d", i), int'(sample_count), (i + 1) % 16);
        end
        check("wrap_no_overrun", int'({overrun, busy}), 0);

        // Reset in the middle of PROC_WAIT aborts and restarts the divider.
        do_reset();
        repeat (11) step();
        adc_ack = 1'b1; step(); adc_ack = 1'b0;
        repeat (2) step();
        check("rst_in_proc", int'(busy), 1);
        reset = 1'b1; step(); reset = 1'b0;
        check("rst_mid_outputs", int'(outs()), 0);
        repeat (9) step();
        check("rst_no_early_tick", int'(tick), 0);
        step();
        check("rst_tick_after10", int'(tick), 1);

        // Enable low freezes the divider at 4.
        do_reset();
        repeat (4) step();
        enable = 1'b0;
        for (int i = 0; i < 7; i++) begin
            step();
            check($sformatf("frz_no_tick%0d", i), int'({tick, adc_req}), 0);
        end
        enable = 1'b1;
        repeat (5) step();
        check("frz_resume_no_tick", int'(tick), 0);
        step();
        check("frz_resume_tick", int'(tick), 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/sample_sequencer.md
SAMPLE_SEQUENCER -- requirements
Module: sample_sequencer

Interface
REQ-001 Parameter DIV, default 50000: sample period in clock cycles, legal range 2..65535.
REQ-002 Parameter CNT_BITS, default 16: width of the divider counter and of sample_count.
REQ-003 clock  in  1  sole clock; all state updates on rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 enable  in  1  high = divider runs and new sample sequences may start.
REQ-006 adc_req  out  1  level request to ADC interface for one sample.
REQ-007 adc_ack  in  1  ADC sample available; sampled only in ADC_WAIT.
REQ-008 proc_start  out  1  one-cycle pulse starting the audio processing datapath.
REQ-009 proc_done  in  1  processing finished; sampled only in PROC_WAIT.
REQ-010 dac_req  out  1  level request to DAC interface for the processed sample.
REQ-011 dac_ack  in  1  DAC accepted sample; sampled only in DAC_WAIT.
REQ-012 tick  out  1  one-cycle sample-period strobe from internal divider.
REQ-013 busy  out  1  high whenever FSM is not IDLE.
REQ-014 overrun  out  1  sticky flag: a tick arrived while a sequence was in progress.
REQ-015 clear_overrun  in  1  synchronous clear of overrun.
REQ-016 sample_count  out  CNT_BITS  completed sequences, modulo 2^CNT_BITS.

Function
REQ-017 Divider counter SHALL increment each cycle enable is high, count 0..DIV-1, wrap to 0 after DIV-1.
REQ-018 tick SHALL be registered, high for exactly the one cycle following the edge at which the counter wrapped: one tick per DIV enabled cycles; first tick follows the DIV-th enabled edge after reset.
REQ-019 enable low SHALL freeze the counter (no reset of its value) and suppress tick; an in-progress sequence SHALL still run to completion.
REQ-020 FSM states: IDLE, ADC_WAIT, PROC_WAIT, DAC_WAIT.
REQ-021 IDLE -> ADC_WAIT on an edge where tick=1; adc_req high from that edge until exit from ADC_WAIT.
REQ-022 ADC_WAIT -> PROC_WAIT on edge with adc_ack=1; adc_req low and proc_start high for exactly the first PROC_WAIT cycle.
REQ-023 PROC_WAIT -> DAC_WAIT on edge with proc_done=1, including proc_done during the proc_start cycle; dac_req high throughout DAC_WAIT.
REQ-024 DAC_WAIT -> IDLE on edge with dac_ack=1; sample_count SHALL increment by 1 on that edge, wrapping from 2^CNT_BITS-1 to 0.
REQ-025 No timeout; FSM SHALL wait indefinitely in any wait state.
REQ-026 Ack/done inputs outside their own state SHALL be ignored.
REQ-027 Tick while FSM not IDLE (including the DAC_WAIT->IDLE edge) SHALL set overrun and be dropped; no sequence queued.
REQ-028 clear_overrun and a set condition on the same edge: set wins, overrun stays 1.
REQ-029 All outputs SHALL be driven from registers (no combinational input-to-output paths).

Reset
REQ-030 reset SHALL force: divider counter 0, tick 0, FSM IDLE, adc_req 0, proc_start 0, dac_req 0, busy 0, overrun 0, sample_count 0.
REQ-031 reset asserted mid-sequence SHALL abort it on that edge with no sample_count increment; reset has priority over all other inputs.

Structure
REQ-032 FSM state encoding and DIV default SHALL live in shared package audio_seq_pkg.
REQ-033 Divider SHALL be sub-module tick_gen (parameters DIV, CNT_BITS; ports clock, reset, enable, tick); sequencer FSM and counters in sample_sequencer.

Verification (DIV=10, CNT_BITS=4)
REQ-034 Reset release, enable=1 held, no acks -> tick high after 10th edge, then every 10 cycles; adc_req rises the edge after first tick.
REQ-035 Full sequence, adc_ack 2 cycles after req, proc_done 3 cycles after start, dac_ack 1 cycle after req -> proc_start exactly 1 cycle, busy high throughout, sample_count 0->1.
REQ-036 Hold proc_done low for 25 cycles -> overrun set at 2nd tick, stays set; clear_overrun pulse with no tick -> 0; clear coincident with tick -> stays 1.
REQ-037 16 complete sequences -> sample_count wraps 15->0 and no overrun.
REQ-038 reset pulse in PROC_WAIT -> next cycle all outputs at reset values, next tick 10 enabled cycles later.
REQ-039 enable low for 7 cycles at counter=4 -> no tick; counter resumes at 4, tick 6 enabled cycles after re-enable.
